// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer
// Holds all members of one clock group in reset, releases them in index order,
// then services a gate request/acknowledge handshake, draining members to idle
// before switching their clock enables off.
//
// Optional feature macro: CLKGRP_SEQ_STAGGER_EN
//   defined   -> members released one at a time, STAGGER cycles apart
//   undefined -> all members released together at the end of HOLD
//
// Handshake: gate_req is a level request. gate_ack rises only once every member
// has shown idle on two consecutive samples. It stays high while the clocks are
// gated and falls on the edge after gate_req is seen low. A drain that times out
// returns to RUN with a one-cycle gate_err pulse. It then ignores gate_req until
// gate_req has been seen low at least once.
module clock_group_reset_sequencer #(
   parameter int NUM_MEMBERS   = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int STAGGER       = 2,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   sw_reset_req,
   input  logic                   gate_req,
   input  logic [NUM_MEMBERS-1:0] member_idle,
   output logic [NUM_MEMBERS-1:0] member_reset,
   output logic [NUM_MEMBERS-1:0] member_clk_en,
   output logic                   gate_ack,
   output logic                   gate_err,
   output logic [2:0]             state
);

   localparam int MAX_HS = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
   localparam int MAXV   = (MAX_HS > DRAIN_TIMEOUT) ? MAX_HS : DRAIN_TIMEOUT;
   localparam int CW     = $clog2(MAXV + 1);
   localparam int IW     = $clog2(NUM_MEMBERS + 1);

   localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER - 1);
   localparam logic [CW-1:0] DRAIN_LAST   = CW'(DRAIN_TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_MEMBER  = IW'(NUM_MEMBERS - 1);

   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_RELEASE = 3'd1,
      S_RUN     = 3'd2,
      S_DRAIN   = 3'd3,
      S_GATED   = 3'd4
   } seq_state_t;

   seq_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;      // number of members already released
   logic             idle_seen_q, idle_seen_d;
   logic             armed_q, armed_d;
   logic             err_d;
   logic             all_idle;

   logic [NUM_MEMBERS-1:0] member_reset_d;
   logic [NUM_MEMBERS-1:0] member_clk_en_d;
   logic                   gate_ack_d;

   assign all_idle = &member_idle;
   assign state    = state_q;

   // State register plus the registered copies of every output
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_HOLD;
         cnt_q         <= '0;
         idx_q         <= '0;
         idle_seen_q   <= 1'b0;
         armed_q       <= 1'b1;
         member_reset  <= '1;
         member_clk_en <= '1;
         gate_ack      <= 1'b0;
         gate_err      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         idle_seen_q   <= idle_seen_d;
         armed_q       <= armed_d;
         member_reset  <= member_reset_d;
         member_clk_en <= member_clk_en_d;
         gate_ack      <= gate_ack_d;
         gate_err      <= err_d;
      end
   end

   // Next-state, counter, member index and armed-flag logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      idle_seen_d = idle_seen_q;
      armed_d     = armed_q;
      err_d       = 1'b0;

      if (!gate_req) armed_d = 1'b1;

      if (sw_reset_req) begin
         state_d     = S_HOLD;
         cnt_d       = '0;
         idx_d       = '0;
         idle_seen_d = 1'b0;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d = '0;
                  idx_d = IW'(1);
                  if (NUM_MEMBERS == 1) begin
                     state_d = S_RUN;
                  end else begin
`ifdef CLKGRP_SEQ_STAGGER_EN
                     state_d = S_RELEASE;
`else
                     state_d = S_RUN;
`endif
                  end
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_RELEASE: begin
               if (cnt_q == STAGGER_LAST) begin
                  cnt_d = '0;
                  idx_d = idx_q + IW'(1);
                  if (idx_q == LAST_MEMBER) state_d = S_RUN;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_RUN: begin
               if (gate_req && armed_q) begin
                  state_d     = S_DRAIN;
                  cnt_d       = '0;
                  idle_seen_d = 1'b0;
               end
            end
            S_DRAIN: begin
               if (!gate_req) begin
                  state_d = S_RUN;
               end else if (all_idle && idle_seen_q) begin
                  state_d = S_GATED;
               end else if (cnt_q == DRAIN_LAST) begin
                  state_d = S_RUN;
                  err_d   = 1'b1;
                  armed_d = 1'b0;
               end else begin
                  if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
                  idle_seen_d = all_idle;
               end
            end
            S_GATED: begin
               if (!gate_req) state_d = S_RUN;
            end
            default: state_d = S_HOLD;
         endcase
      end
   end

   // Output values for the next cycle, derived from the upcoming state
   always_comb begin
      member_reset_d  = '0;
      member_clk_en_d = '1;
      gate_ack_d      = 1'b0;
      case (state_d)
         S_HOLD:    member_reset_d = '1;
         S_RELEASE: begin
            for (int i = 0; i < NUM_MEMBERS; i++)
               member_reset_d[i] = (IW'(i) >= idx_d);
         end
         S_GATED: begin
            member_clk_en_d = '0;
            gate_ack_d      = 1'b1;
         end
         default: member_reset_d = '0;
      endcase
   end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed bench for clock_group_reset_sequencer with default parameters.
// Expected release timing follows CLKGRP_SEQ_STAGGER_EN when it is defined.
module tb_clock_group_reset_sequencer;

   localparam int N    = 4;
   localparam int HOLD = 16;
   localparam int STG  = 2;
   localparam int TMO  = 64;

   localparam logic [2:0] ST_HOLD    = 3'd0;
   localparam logic [2:0] ST_RELEASE = 3'd1;
   localparam logic [2:0] ST_RUN     = 3'd2;
   localparam logic [2:0] ST_DRAIN   = 3'd3;
   localparam logic [2:0] ST_GATED   = 3'd4;

   logic         clock;
   logic         reset;
   logic         sw_reset_req;
   logic         gate_req;
   logic [N-1:0] member_idle;
   logic [N-1:0] member_reset;
   logic [N-1:0] member_clk_en;
   logic         gate_ack;
   logic         gate_err;
   logic [2:0]   state;

   int n_checks = 0;
   int n_fail   = 0;

   clock_group_reset_sequencer #(
      .NUM_MEMBERS(N), .HOLD_CYCLES(HOLD), .STAGGER(STG), .DRAIN_TIMEOUT(TMO)
   ) dut (
      .clock(clock), .reset(reset), .sw_reset_req(sw_reset_req),
      .gate_req(gate_req), .member_idle(member_idle),
      .member_reset(member_reset), .member_clk_en(member_clk_en),
      .gate_ack(gate_ack), .gate_err(gate_err), .state(state)
   );

   // Clock generation
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle before sampling
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 32'(state), 32'(ST_HOLD));
      check({tag, "_rst"},   32'(member_reset), 32'hF);
      check({tag, "_clken"}, 32'(member_clk_en), 32'hF);
      check({tag, "_ack"},   32'(gate_ack), 32'h0);
      check({tag, "_err"},   32'(gate_err), 32'h0);
   endtask

   // Expected member_reset after edge e of a release sequence
   function automatic logic [N-1:0] exp_rst(input int e);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
`ifdef CLKGRP_SEQ_STAGGER_EN
         r[i] = (e < HOLD + i * STG);
`else
         r[i] = (e < HOLD);
`endif
      end
      return r;
   endfunction

   function automatic logic [2:0] exp_state(input int e);
`ifdef CLKGRP_SEQ_STAGGER_EN
      if (e < HOLD) return ST_HOLD;
      if (e < HOLD + (N - 1) * STG) return ST_RELEASE;
      return ST_RUN;
`else
      if (e < HOLD) return ST_HOLD;
      return ST_RUN;
`endif
   endfunction

   // Step through edges 1..last of a release sequence and check each edge
   task automatic run_release(input string tag, input int last);
      for (int e = 1; e <= last; e++) begin
         tick();
         check({tag, "_rst"},   32'(member_reset), 32'(exp_rst(e)));
         check({tag, "_state"}, 32'(state), 32'(exp_state(e)));
         check({tag, "_clken"}, 32'(member_clk_en), 32'hF);
      end
   endtask

   initial begin
      reset        = 1'b0;
      sw_reset_req = 1'b0;
      gate_req     = 1'b0;
      member_idle  = 4'hF;

      // Reset values while reset is held low
      #22;
      check_reset_values("por");

      // Power-on release sequence
      @(negedge clock);
      reset = 1'b1;
      run_release("por_seq", 24);

      // Gate handshake with members already idle
      gate_req = 1'b1;
      tick();
      check("gate_drain_state", 32'(state), 32'(ST_DRAIN));
      tick();
      check("gate_drain2_state", 32'(state), 32'(ST_DRAIN));
      check("gate_drain2_ack", 32'(gate_ack), 32'h0);
      tick();
      check("gated_state", 32'(state), 32'(ST_GATED));
      check("gated_clken", 32'(member_clk_en), 32'h0);
      check("gated_ack",   32'(gate_ack), 32'h1);
      gate_req = 1'b0;
      tick();
      check("ungate_state", 32'(state), 32'(ST_RUN));
      check("ungate_clken", 32'(member_clk_en), 32'hF);
      check("ungate_ack",   32'(gate_ack), 32'h0);

      // Drain timeout with member 3 busy
      member_idle = 4'h7;
      gate_req    = 1'b1;
      tick();
      check("tmo_enter_state", 32'(state), 32'(ST_DRAIN));
      for (int k = 1; k < TMO; k++) begin
         tick();
         check("tmo_wait_err", 32'(gate_err), 32'h0);
      end
      check("tmo_last_state", 32'(state), 32'(ST_DRAIN));
      tick();
      check("tmo_state", 32'(state), 32'(ST_RUN));
      check("tmo_err",   32'(gate_err), 32'h1);
      check("tmo_ack",   32'(gate_ack), 32'h0);
      tick();
      check("tmo_err_pulse", 32'(gate_err), 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("tmo_disarmed_state", 32'(state), 32'(ST_RUN));
      end
      gate_req = 1'b0;
      tick();
      check("rearm_state", 32'(state), 32'(ST_RUN));
      gate_req = 1'b1;
      tick();
      check("rearm_drain_state", 32'(state), 32'(ST_DRAIN));
      gate_req = 1'b0;
      tick();
      check("drop_in_drain_state", 32'(state), 32'(ST_RUN));
      check("drop_in_drain_ack",   32'(gate_ack), 32'h0);

      // Software reset while gated
      member_idle = 4'hF;
      gate_req    = 1'b1;
      tick();
      tick();
      tick();
      check("sw_pre_state", 32'(state), 32'(ST_GATED));
      sw_reset_req = 1'b1;
      gate_req     = 1'b0;
      tick();
      check_reset_values("sw");
      tick();
      check("sw_held_state", 32'(state), 32'(ST_HOLD));
      sw_reset_req = 1'b0;
      run_release("sw_seq", 24);

      // Asynchronous reset in the middle of a release sequence
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      for (int e = 1; e <= 19; e++) tick();
      check("mid_rst_pre", 32'(member_reset), 32'(exp_rst(19)));
      #2;
      reset = 1'b0;
      #1;
      check_reset_values("async");
      @(negedge clock);
      reset = 1'b1;
      run_release("async_seq", 24);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
